// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch (IF)
// port and the data-memory (MEM) port.
//
// Behaviour
//   - Grants one requester at a time. Data has fixed priority over fetch.
//   - Drives a req/ack handshake toward the memory.
//   - Builds byte strobes and replicated lanes for stores.
//   - Extracts, then sign- or zero-extends, load data.
//   - Flags misaligned data accesses. These are answered without a memory cycle.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   if_req/if_addr          fetch request and byte address (bits [1:0] ignored)
//   if_rdata/if_valid       fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_op      data request, store flag, size/sign code
//   dm_addr/dm_wdata        data byte address and store data
//   dm_rdata/dm_valid       extended load result and one-cycle completion pulse
//   dm_misalign             qualifies dm_valid when the access was misaligned
//   mem_req/mem_we/...      memory handshake: word address, strobes, data, ack
//   stall_if/stall_mem      freeze signals while a port's access is outstanding
module mem_port_arbiter #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [2:0]    dm_op,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_valid,
  output logic          dm_misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic          if_valid_q, if_valid_d;
  logic          dm_valid_q, dm_valid_d;
  logic          dm_misalign_q, dm_misalign_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;

  // Fetch addresses are word-aligned by contract; the low bits carry no information.
  logic unused_if_lsb;
  assign unused_if_lsb = ^if_addr[1:0];

  // Access-size decode. Unlisted codes fall through to word.
  logic op_byte, op_half, op_signed, dm_misaligned;
  always_comb begin
    op_byte       = (dm_op == 3'b010) || (dm_op == 3'b100);
    op_half       = (dm_op == 3'b011) || (dm_op == 3'b101);
    op_signed     = (dm_op == 3'b010) || (dm_op == 3'b011);
    dm_misaligned = op_half ? dm_addr[0] : (!op_byte && (dm_addr[1:0] != 2'b00));
  end

  // Store lane steering: replicate the datum across lanes and let the strobes select.
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  always_comb begin
    st_strb = 4'b1111;
    st_data = dm_wdata;
    if (op_byte) begin
      st_strb = 4'b0001 << dm_addr[1:0];
      st_data = {4{dm_wdata[7:0]}};
    end else if (op_half) begin
      st_strb = dm_addr[1] ? 4'b1100 : 4'b0011;
      st_data = {2{dm_wdata[15:0]}};
    end
  end

  // Load extraction. The dm_* inputs stay stable until dm_valid, so the live address
  // and op code are still correct in the ack cycle.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  always_comb begin
    ld_byte = mem_rdata[{dm_addr[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{dm_addr[1], 4'b0000} +: 16];
    ld_data = mem_rdata;
    if (op_byte) begin
      ld_data = {{24{op_signed & ld_byte[7]}}, ld_byte};
    end else if (op_half) begin
      ld_data = {{16{op_signed & ld_half[15]}}, ld_half};
    end
  end

  // A port whose valid pulse is high this cycle has already been served. Its request
  // is still asserted, but it must not be granted again.
  logic dm_go, if_go, ack_seen;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    if_valid_d    = 1'b0;
    dm_valid_d    = 1'b0;
    dm_misalign_d = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    dm_go         = dm_req & ~dm_valid_q;
    if_go         = if_req & ~if_valid_q;
    ack_seen      = mem_ack & mem_req_q;

    unique case (state_q)
      StIdle: begin
        if (dm_go) begin
          if (dm_misaligned) begin
            // Answered locally; the fetch waits one cycle.
            dm_valid_d    = 1'b1;
            dm_misalign_d = 1'b1;
            dm_rdata_d    = '0;
          end else begin
            state_d     = StBusyD;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = {dm_addr[AW-1:2], 2'b00};
            mem_wstrb_d = dm_we ? st_strb : 4'b0000;
            mem_wdata_d = dm_we ? st_data : '0;
          end
        end else if (if_go) begin
          state_d     = StBusyI;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[AW-1:2], 2'b00};
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = '0;
        end
      end
      StBusyI: begin
        if (ack_seen) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      StBusyD: begin
        if (ack_seen) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          dm_rdata_d = mem_we_q ? 32'h0 : ld_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= 4'b0000;
      if_valid_q    <= 1'b0;
      dm_valid_q    <= 1'b0;
      dm_misalign_q <= 1'b0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      if_valid_q    <= if_valid_d;
      dm_valid_q    <= dm_valid_d;
      dm_misalign_q <= dm_misalign_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign if_valid    = if_valid_q;
  assign if_rdata    = if_rdata_q;
  assign dm_valid    = dm_valid_q;
  assign dm_misalign = dm_misalign_q;
  assign dm_rdata    = dm_rdata_q;
  assign stall_if    = if_req & ~if_valid_q;
  assign stall_mem   = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
//
// - Stimulus pushes the expected memory transactions into mem_q.
// - Stimulus pushes the expected completions into if_q and dm_q.
// - The memory model checks each transaction as it starts, then acks after the
//   queued number of wait cycles.
// - The monitor checks every valid pulse against the completion queues.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [2:0]  dm_op;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, dm_misalign, mem_req, mem_we, stall_if, stall_mem;
  logic [3:0]  mem_wstrb;

  mem_port_arbiter #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_op(dm_op), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_misalign(dm_misalign), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          chk_wd;
    logic [31:0] rdata;
    int          wait_n;
    int          start;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          at;
  } resp_t;

  mem_exp_t mem_q[$];
  resp_t    if_q[$];
  resp_t    dm_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model
  bit       mem_auto = 1'b1;
  bit       in_txn = 1'b0;
  int       mem_cnt = 0;
  mem_exp_t cur;

  always @(negedge clk) begin
    if (mem_auto) begin
      if (mem_req) begin
        if (!in_txn) begin
          in_txn  = 1'b1;
          mem_cnt = 0;
          if (mem_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mem_unexpected: got mem_req at cycle %0d, required none", cyc);
            cur.rdata  = 32'h0;
            cur.wait_n = 0;
          end else begin
            cur = mem_q.pop_front();
            chk("mem_start_cycle", cyc, cur.start);
            chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
            if (cur.chk_wd) chk("mem_wdata", mem_wdata, cur.wdata);
          end
          mem_rdata = cur.rdata;
        end
        mem_ack = (mem_cnt == cur.wait_n);
        mem_cnt++;
      end else begin
        in_txn  = 1'b0;
        mem_ack = 1'b0;
      end
    end
  end

  // Completion monitor
  resp_t r_if, r_dm;
  always @(negedge clk) begin
    if (rst_n && if_valid) begin
      if (if_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL if_unexpected: got if_valid at cycle %0d, required none", cyc);
      end else begin
        r_if = if_q.pop_front();
        chk("if_rdata", if_rdata, r_if.rdata);
        chk("if_valid_cycle", cyc, r_if.at);
      end
    end
    if (rst_n && dm_valid) begin
      if (dm_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dm_unexpected: got dm_valid at cycle %0d, required none", cyc);
      end else begin
        r_dm = dm_q.pop_front();
        chk("dm_rdata", dm_rdata, r_dm.rdata);
        chk("dm_misalign", {31'b0, dm_misalign}, {31'b0, r_dm.mis});
        chk("dm_valid_cycle", cyc, r_dm.at);
      end
    end
  end

  // Keeps each request asserted until its valid pulse, then drops it on the next cycle.
  task automatic run_until_done(input bit want_if, input bit want_dm);
    bit if_done;
    bit dm_done;
    int n;
    if_done = !want_if;
    dm_done = !want_dm;
    n = 0;
    while (!(if_done && dm_done) && n < 60) begin
      @(negedge clk);
      if (if_valid) if_done = 1'b1;
      if (dm_valid) dm_done = 1'b1;
      @(posedge clk); #1;
      if (if_done) if_req = 1'b0;
      if (dm_done) dm_req = 1'b0;
      n++;
    end
    if (!(if_done && dm_done)) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: if_done=%0d dm_done=%0d, required both 1", if_done, dm_done);
      if_req = 1'b0;
      dm_req = 1'b0;
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd, input logic [31:0] rd, input int w,
                          input int start);
    mem_exp_t e;
    e.we     = we;
    e.addr   = addr;
    e.wstrb  = strb;
    e.wdata  = wd;
    e.chk_wd = we;
    e.rdata  = rd;
    e.wait_n = w;
    e.start  = start;
    mem_q.push_back(e);
  endtask

  task automatic push_resp(input bit is_dm, input logic [31:0] rd, input logic mis, input int at);
    resp_t e;
    e.rdata = rd;
    e.mis   = mis;
    e.at    = at;
    if (is_dm) dm_q.push_back(e);
    else if_q.push_back(e);
  endtask

  // Expected values are hand-computed constants passed in by the caller.
  task automatic do_dm(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int w,
                       input logic [31:0] exp_rd, input logic mis, input logic [31:0] exp_addr,
                       input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    int c0;
    c0 = cyc;
    dm_we = we;
    dm_op = op;
    dm_addr = addr;
    dm_wdata = wd;
    dm_req = 1'b1;
    if (mis) begin
      push_resp(1'b1, exp_rd, 1'b1, c0 + 1);
    end else begin
      push_mem(we, exp_addr, exp_strb, exp_wd, rd, w, c0 + 1);
      push_resp(1'b1, exp_rd, 1'b0, c0 + 2 + w);
    end
    run_until_done(1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c0;
    rst_n = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_op = 3'b001;
    if_addr = '0;
    dm_addr = '0;
    dm_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_dm_valid", {31'b0, dm_valid}, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset in the middle of a data access; the late ack must be ignored.
    mem_auto = 1'b0;
    dm_we = 1'b0;
    dm_op = 3'b001;
    dm_addr = 32'h300;
    dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_mem_req_before", {31'b0, mem_req}, 32'h1);
    chk("midrst_mem_addr", mem_addr, 32'h300);
    @(posedge clk); #1;
    rst_n = 1'b0;
    dm_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("midrst_mem_req_after", {31'b0, mem_req}, 32'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("midrst_no_dm_valid", {31'b0, dm_valid}, 32'h0);
    chk("midrst_mem_req_idle", {31'b0, mem_req}, 32'h0);
    @(posedge clk); #1;
    mem_auto = 1'b1;

    // Fetch only, zero wait.
    c0 = cyc;
    if_addr = 32'h104;
    if_req = 1'b1;
    push_mem(1'b0, 32'h104, 4'b0000, 32'h0, 32'h00500093, 0, c0 + 1);
    push_resp(1'b0, 32'h00500093, 1'b0, c0 + 2);
    @(negedge clk);
    chk("fetch_stall_c0", {31'b0, stall_if}, 32'h1);
    @(negedge clk);
    chk("fetch_stall_c1", {31'b0, stall_if}, 32'h1);
    @(negedge clk);
    chk("fetch_stall_c2", {31'b0, stall_if}, 32'h0);
    chk("fetch_valid_c2", {31'b0, if_valid}, 32'h1);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Contention: data (2 waits) first, fetch (1 wait) after.
    c0 = cyc;
    if_addr = 32'h108;
    if_req = 1'b1;
    dm_we = 1'b0;
    dm_op = 3'b001;
    dm_addr = 32'h200;
    dm_req = 1'b1;
    push_mem(1'b0, 32'h200, 4'b0000, 32'h0, 32'h11223344, 2, c0 + 1);
    push_mem(1'b0, 32'h108, 4'b0000, 32'h0, 32'h00A00113, 1, c0 + 5);
    push_resp(1'b1, 32'h11223344, 1'b0, c0 + 4);
    push_resp(1'b0, 32'h00A00113, 1'b0, c0 + 7);
    @(negedge clk);
    chk("cont_stall_mem", {31'b0, stall_mem}, 32'h1);
    chk("cont_stall_if", {31'b0, stall_if}, 32'h1);
    run_until_done(1'b1, 1'b1);

    // Loads from 0x80F07F81.
    do_dm(1'b0, 3'b010, 32'h203, 32'h0, 32'h80F07F81, 0, 32'hFFFFFF80, 1'b0, 32'h200, 4'h0, 32'h0);
    do_dm(1'b0, 3'b100, 32'h200, 32'h0, 32'h80F07F81, 1, 32'h00000081, 1'b0, 32'h200, 4'h0, 32'h0);
    do_dm(1'b0, 3'b011, 32'h202, 32'h0, 32'h80F07F81, 0, 32'hFFFF80F0, 1'b0, 32'h200, 4'h0, 32'h0);
    do_dm(1'b0, 3'b101, 32'h202, 32'h0, 32'h80F07F81, 0, 32'h000080F0, 1'b0, 32'h200, 4'h0, 32'h0);
    do_dm(1'b0, 3'b011, 32'h200, 32'h0, 32'h80F07F81, 0, 32'h00007F81, 1'b0, 32'h200, 4'h0, 32'h0);
    do_dm(1'b0, 3'b111, 32'h204, 32'h0, 32'h80F07F81, 0, 32'h80F07F81, 1'b0, 32'h204, 4'h0, 32'h0);

    // Stores of 0x123456AB.
    do_dm(1'b1, 3'b010, 32'h101, 32'h123456AB, 32'hDEADBEEF, 0, 32'h0, 1'b0, 32'h100, 4'b0010,
          32'hABABABAB);
    do_dm(1'b1, 3'b011, 32'h102, 32'h123456AB, 32'hDEADBEEF, 1, 32'h0, 1'b0, 32'h100, 4'b1100,
          32'h56AB56AB);
    do_dm(1'b1, 3'b001, 32'h104, 32'h123456AB, 32'hDEADBEEF, 0, 32'h0, 1'b0, 32'h104, 4'b1111,
          32'h123456AB);

    // Misaligned half store: no memory cycle.
    do_dm(1'b1, 3'b011, 32'h101, 32'h123456AB, 32'h0, 0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);

    // Misaligned word load with a pending fetch; the fetch goes one cycle later.
    c0 = cyc;
    if_addr = 32'h10C;
    if_req = 1'b1;
    dm_we = 1'b0;
    dm_op = 3'b001;
    dm_addr = 32'h102;
    dm_req = 1'b1;
    push_resp(1'b1, 32'h0, 1'b1, c0 + 1);
    push_mem(1'b0, 32'h10C, 4'b0000, 32'h0, 32'h00000013, 0, c0 + 2);
    push_resp(1'b0, 32'h00000013, 1'b0, c0 + 3);
    run_until_done(1'b1, 1'b1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mem_q_drained", mem_q.size(), 32'h0);
    chk("if_q_drained", if_q.size(), 32'h0);
    chk("dm_q_drained", dm_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
